// File: rtl/rv32_decode_stage.sv
// RV32I/RV32E decode stage: combinational decode into a DEPTH-entry
// valid/ready queue, with flush, illegal detection and illegal count.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 drop queue and same-cycle input
//   in_valid/in_ready     input handshake
//   in_inst, in_pc        instruction word and its PC
//   out_valid/out_ready   output handshake, head entry shown
//   out_inst, out_pc      pass-through of word and PC
//   out_imm, out_rs1/2/rd immediate and raw register fields
//   out_fmt, out_alu_op   format and ALU operation
//   out_rd_we, out_illegal
//   illegal_cnt           saturating count of accepted illegals
module rv32_decode_stage #(
  parameter bit          RVE      = 1'b0,
  parameter bit          EN_ZICSR = 1'b1,
  parameter bit          EN_FENCE = 1'b1,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_fmt,
  output logic [3:0]  out_alu_op,
  output logic        out_rd_we,
  output logic        out_illegal,
  output logic [15:0] illegal_cnt
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  localparam logic [11:0] F12_ECALL  = 12'h000;
  localparam logic [11:0] F12_EBREAK = 12'h001;
  localparam logic [11:0] F12_SRET   = 12'h102;
  localparam logic [11:0] F12_MRET   = 12'h302;
  localparam logic [11:0] F12_WFI    = 12'h105;

  localparam logic [2:0] F_R   = 3'd0;
  localparam logic [2:0] F_I   = 3'd1;
  localparam logic [2:0] F_S   = 3'd2;
  localparam logic [2:0] F_B   = 3'd3;
  localparam logic [2:0] F_U   = 3'd4;
  localparam logic [2:0] F_J   = 3'd5;
  localparam logic [2:0] F_SYS = 3'd6;
  localparam logic [2:0] F_ILL = 3'd7;

  localparam logic [3:0] A_ADD = 4'd0;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [3:0]  alu;
    logic        we;
    logic        ill;
  } ent_t;

  function automatic logic [3:0] alu_of(
    input logic [2:0] f3,
    input logic       alt
  );
    unique case (f3)
      3'b000:  alu_of = alt ? 4'd1 : 4'd0;
      3'b001:  alu_of = 4'd2;
      3'b010:  alu_of = 4'd3;
      3'b011:  alu_of = 4'd4;
      3'b100:  alu_of = 4'd5;
      3'b101:  alu_of = alt ? 4'd7 : 4'd6;
      3'b110:  alu_of = 4'd8;
      default: alu_of = 4'd9;
    endcase
  endfunction

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    nxt = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] f12;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i;

  assign opc   = in_inst[6:0];
  assign f3    = in_inst[14:12];
  assign f7    = in_inst[31:25];
  assign f12   = in_inst[31:20];
  assign rs1   = in_inst[19:15];
  assign rs2   = in_inst[24:20];
  assign rd    = in_inst[11:7];
  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};

  logic u1, u2, ud, wb, bad;
  ent_t dec;

  always_comb begin
    dec      = '0;
    dec.inst = in_inst;
    dec.pc   = in_pc;
    dec.fmt  = F_ILL;
    dec.alu  = A_ADD;
    u1 = 1'b0; u2 = 1'b0; ud = 1'b0;
    wb = 1'b0; bad = 1'b0;
    unique case (opc)
      OP_LUI, OP_AUIPC: begin
        dec.fmt = F_U;
        dec.imm = {in_inst[31:12], 12'b0};
        ud = 1'b1; wb = 1'b1;
      end
      OP_JAL: begin
        dec.fmt = F_J;
        dec.imm = {{11{in_inst[31]}}, in_inst[31],
                   in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
        ud = 1'b1; wb = 1'b1;
      end
      OP_JALR: begin
        dec.fmt = F_I;
        dec.imm = imm_i;
        u1 = 1'b1; ud = 1'b1; wb = 1'b1;
        bad = (f3 != 3'b000);
      end
      OP_BR: begin
        dec.fmt = F_B;
        dec.imm = {{19{in_inst[31]}}, in_inst[31],
                   in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        u1 = 1'b1; u2 = 1'b1;
        bad = (f3[2:1] == 2'b01);
      end
      OP_LD: begin
        dec.fmt = F_I;
        dec.imm = imm_i;
        u1 = 1'b1; ud = 1'b1; wb = 1'b1;
        bad = (f3 == 3'b011) || (f3[2:1] == 2'b11);
      end
      OP_ST: begin
        dec.fmt = F_S;
        dec.imm = {{20{in_inst[31]}},
                   in_inst[31:25], in_inst[11:7]};
        u1 = 1'b1; u2 = 1'b1;
        bad = (f3 > 3'b010);
      end
      OP_IMM: begin
        dec.fmt = F_I;
        dec.imm = imm_i;
        dec.alu = alu_of(f3,
                         in_inst[30] && f3 == 3'b101);
        u1 = 1'b1; ud = 1'b1; wb = 1'b1;
        bad = (f3 == 3'b001 && f7 != 7'h00) ||
              (f3 == 3'b101 && f7 != 7'h00 &&
               f7 != 7'h20);
      end
      OP_OP: begin
        dec.fmt = F_R;
        dec.alu = alu_of(f3, in_inst[30]);
        u1 = 1'b1; u2 = 1'b1; ud = 1'b1; wb = 1'b1;
        bad = !(f7 == 7'h00 ||
                (f7 == 7'h20 &&
                 (f3 == 3'b000 || f3 == 3'b101)));
      end
      OP_FENCE: begin
        dec.fmt = F_I;
        dec.imm = imm_i;
        bad = !EN_FENCE;
      end
      OP_SYS: begin
        dec.fmt = F_SYS;
        if (f3 == 3'b000) begin
          bad = !(f12 == F12_ECALL  ||
                  f12 == F12_EBREAK ||
                  f12 == F12_SRET   ||
                  f12 == F12_MRET   ||
                  f12 == F12_WFI);
        end else begin
          // f3[2] selects the uimm CSR forms
          dec.imm = f3[2] ? {27'b0, rs1} : '0;
          u1 = !f3[2]; ud = 1'b1; wb = 1'b1;
          bad = (f3 == 3'b100) || !EN_ZICSR;
        end
      end
      default: bad = 1'b1;
    endcase
    if (RVE && ((u1 && rs1[4]) ||
                (u2 && rs2[4]) ||
                (ud && rd[4])))
      bad = 1'b1;
    if (bad) begin
      dec.fmt = F_ILL;
      dec.imm = '0;
      dec.alu = A_ADD;
    end
    dec.ill = bad;
    dec.we  = wb && !bad && (rd != 5'd0);
  end

  logic [2:0]    cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [15:0]   illegal_cnt_q, illegal_cnt_d;
  ent_t          mem_q [DEPTH];
  logic          push, pop;

  assign in_ready  = (cnt_q < 3'(DEPTH));
  assign out_valid = (cnt_q != 3'd0);
  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    cnt_d = cnt_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    illegal_cnt_d = illegal_cnt_q;
    if (flush) begin
      cnt_d = '0;
      wp_d  = '0;
      rp_d  = '0;
    end else begin
      if (push) wp_d = nxt(wp_q);
      if (pop)  rp_d = nxt(rp_q);
      cnt_d = cnt_q + {2'b0, push} - {2'b0, pop};
      if (push && dec.ill &&
          illegal_cnt_q != 16'hFFFF)
        illegal_cnt_d = illegal_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= dec;
  end

  ent_t head;
  assign head = mem_q[rp_q];

  assign out_inst    = head.inst;
  assign out_pc      = head.pc;
  assign out_imm     = head.imm;
  assign out_rs1     = head.inst[19:15];
  assign out_rs2     = head.inst[24:20];
  assign out_rd      = head.inst[11:7];
  assign out_fmt     = head.fmt;
  assign out_alu_op  = head.alu;
  assign out_rd_we   = head.we;
  assign out_illegal = head.ill;
  assign illegal_cnt = illegal_cnt_q;

endmodule
